// File: rtl/alu_seq_pkg.sv
// Shared types, constants and decode function for the ALU sequencing controller.
// Optional multiply support is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam int unsigned BASE_OP_W = 4;
  localparam int unsigned CODE_W    = 3;

  // ALU control codes
  localparam logic [CODE_W-1:0] CTRL_ADD = 3'd0;
  localparam logic [CODE_W-1:0] CTRL_SUB = 3'd1;
  localparam logic [CODE_W-1:0] CTRL_AND = 3'd2;
  localparam logic [CODE_W-1:0] CTRL_OR  = 3'd3;
  localparam logic [CODE_W-1:0] CTRL_MUL = 3'd4;

  // Opcode values
  localparam logic [BASE_OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [BASE_OP_W-1:0] OP_ADD_A = 4'd1;
  localparam logic [BASE_OP_W-1:0] OP_ADD_B = 4'd2;
  localparam logic [BASE_OP_W-1:0] OP_ADD_C = 4'd3;
  localparam logic [BASE_OP_W-1:0] OP_ADD_D = 4'd4;
  localparam logic [BASE_OP_W-1:0] OP_SUB_A = 4'd5;
  localparam logic [BASE_OP_W-1:0] OP_ADD_E = 4'd8;
  localparam logic [BASE_OP_W-1:0] OP_SUB_B = 4'd9;
  localparam logic [BASE_OP_W-1:0] OP_AND   = 4'd10;
  localparam logic [BASE_OP_W-1:0] OP_OR    = 4'd11;
  localparam logic [BASE_OP_W-1:0] OP_MUL   = 4'd12;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] ctrl;
    logic              is_nop;
    logic              is_mul;
    logic              is_illegal;
  } dec_t;

  // Decode the low opcode nibble; hi_nz flags any set bit above the nibble.
  function automatic dec_t decode_op(input logic [BASE_OP_W-1:0] op, input logic hi_nz);
    dec_t d;
    d.ctrl       = CTRL_ADD;
    d.is_nop     = 1'b0;
    d.is_mul     = 1'b0;
    d.is_illegal = 1'b0;
    if (hi_nz) begin
      d.is_illegal = 1'b1;
    end else begin
      case (op)
        OP_NOP:                                        d.is_nop = 1'b1;
        OP_ADD_A, OP_ADD_B, OP_ADD_C, OP_ADD_D, OP_ADD_E: d.ctrl = CTRL_ADD;
        OP_SUB_A, OP_SUB_B:                            d.ctrl = CTRL_SUB;
        OP_AND:                                        d.ctrl = CTRL_AND;
        OP_OR:                                         d.ctrl = CTRL_OR;
`ifdef ALU_SEQ_MUL_EN
        OP_MUL: begin
          d.ctrl   = CTRL_MUL;
          d.is_mul = 1'b1;
        end
`endif
        default:                                       d.is_illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> ALU control code and class flags.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 3
) (
  input  logic [OPCODE_W-1:0] op_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                is_nop_o,
  output logic                is_mul_o,
  output logic                is_illegal_o
);

  logic hi_nz;
  dec_t dec;

  // Any bit above the base nibble makes the opcode illegal
  if (OPCODE_W > BASE_OP_W) begin : g_wide
    assign hi_nz = |op_i[OPCODE_W-1:BASE_OP_W];
  end else begin : g_narrow
    assign hi_nz = 1'b0;
  end

  // Table lookup through the shared decode function
  always_comb begin
    dec = decode_op(op_i[BASE_OP_W-1:0], hi_nz);
  end

  assign ctrl_o       = CTRL_W'(dec.ctrl);
  assign is_nop_o     = dec.is_nop;
  assign is_mul_o     = dec.is_mul;
  assign is_illegal_o = dec.is_illegal;

endmodule

// File: rtl/alu_seq_controller.sv
// ALU sequencing controller: accepts opcodes, issues registered ALU control
// codes, stalls for multi-cycle multiplies. Multiply support: ALU_SEQ_MUL_EN.
module alu_seq_controller
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 3,
  parameter int unsigned MUL_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] op_in,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [CTRL_W-1:0]   alu_ctrl_out,
  output logic                ctrl_valid,
  output logic                mul_busy,
  output logic                illegal_op
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_nop;
  logic              dec_mul;
  logic              dec_illegal;
  logic              accept;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  alu_op_decode #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W)
  ) u_decode (
    .op_i         (op_in),
    .ctrl_o       (dec_ctrl),
    .is_nop_o     (dec_nop),
    .is_mul_o     (dec_mul),
    .is_illegal_o (dec_illegal)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned     CNT_W    = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // FSM state and multiply countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign mul_busy = (state_q == ST_MUL_WAIT);
`else
  assign op_ready = 1'b1;
  assign mul_busy = 1'b0;
`endif

  assign accept = op_valid && op_ready;

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else if (dec_mul) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_LOAD;
          end else if (!dec_nop) begin
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ctrl_d  = CTRL_W'(CTRL_MUL);
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
`else
    // Multiply opcode decodes as illegal here; is_mul is folded in for completeness
    if (accept) begin
      if (dec_illegal || dec_mul) begin
        illegal_d = 1'b1;
      end else if (!dec_nop) begin
        ctrl_d  = dec_ctrl;
        valid_d = 1'b1;
      end
    end
`endif
  end

  assign alu_ctrl_out = ctrl_q;
  assign ctrl_valid   = valid_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Scoreboard bench for alu_seq_controller (covers both ALU_SEQ_MUL_EN builds).
module tb_alu_seq_controller;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned CTRL_W   = 3;
  localparam int unsigned MUL_LAT  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [OPCODE_W-1:0] op_in;
  logic                op_valid;
  logic                op_ready;
  logic [CTRL_W-1:0]   alu_ctrl_out;
  logic                ctrl_valid;
  logic                mul_busy;
  logic                illegal_op;

  typedef struct {
    int unsigned ctrl;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass  = 0;

  alu_seq_controller #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .op_in        (op_in),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .alu_ctrl_out (alu_ctrl_out),
    .ctrl_valid   (ctrl_valid),
    .mul_busy     (mul_busy),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every ctrl_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && ctrl_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ctrl_valid", 32'(ctrl_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("ctrl_value", 32'(alu_ctrl_out), mon_e.ctrl);
        check("ctrl_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    op_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Present one opcode for one edge; optionally expect a pulse one cycle later
  task automatic send(input int unsigned op, input bit exp_v, input int unsigned exp_c);
    op_in    = OPCODE_W'(op);
    op_valid = 1'b1;
    if (exp_v) sb.push_back('{exp_c, cyc + 1});
    tick();
    op_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_op_ready"},   32'(op_ready),     1);
    check({tag, "_mul_busy"},   32'(mul_busy),     0);
    check({tag, "_ctrl_valid"}, 32'(ctrl_valid),   0);
    check({tag, "_alu_ctrl"},   32'(alu_ctrl_out), 0);
    check({tag, "_illegal"},    32'(illegal_op),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    op_in    = '0;
    op_valid = 1'b0;
    do_reset();
    check_reset_state("reset");

    // Back-to-back single-cycle opcodes
    send(1, 1, 0);
    send(8, 1, 0);
    send(9, 1, 1);
    send(10, 1, 2);
    send(11, 1, 3);
    send(2, 1, 0);
    send(5, 1, 1);
    check("b2b_op_ready", 32'(op_ready), 1);
    idle(2);
    check("hold_after_sub", 32'(alu_ctrl_out), 1);

    // NOP leaves the control code untouched
    send(0, 0, 0);
    idle(1);
    check("nop_hold", 32'(alu_ctrl_out), 1);
    check("nop_no_illegal", 32'(illegal_op), 0);

    // Illegal opcode is sticky until reset
    send(13, 0, 0);
    check("illegal_set", 32'(illegal_op), 1);
    check("illegal_hold_ctrl", 32'(alu_ctrl_out), 1);
    send(0, 0, 0);
    idle(20);
    check("illegal_sticky", 32'(illegal_op), 1);

    // Another illegal value, then normal operation resumes
    do_reset();
    check("reset_clears_illegal", 32'(illegal_op), 0);
    send(7, 0, 0);
    check("illegal7_set", 32'(illegal_op), 1);
    send(4, 1, 0);
    send(3, 1, 0);
    send(11, 1, 3);
    idle(1);

    // Reset wins over a simultaneous accept
    rst      = 1'b1;
    op_in    = OPCODE_W'(10);
    op_valid = 1'b1;
    tick();
    rst      = 1'b0;
    op_valid = 1'b0;
    check_reset_state("rst_prio");
    idle(2);

`ifdef ALU_SEQ_MUL_EN
    // Multiply occupancy with a held follow-on opcode
    op_in    = OPCODE_W'(12);
    op_valid = 1'b1;
    sb.push_back('{4, cyc + 1 + MUL_LAT});
    tick();
    op_in = OPCODE_W'(3);
    sb.push_back('{0, cyc + MUL_LAT + 1});
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      check("mul_wait_ready", 32'(op_ready), 0);
      check("mul_wait_busy",  32'(mul_busy), 1);
      tick();
    end
    check("mul_done_ready", 32'(op_ready),     1);
    check("mul_done_busy",  32'(mul_busy),     0);
    check("mul_done_valid", 32'(ctrl_valid),   1);
    check("mul_done_ctrl",  32'(alu_ctrl_out), 4);
    tick();
    op_valid = 1'b0;
    check("held_op_ctrl", 32'(alu_ctrl_out), 0);
    idle(2);

    // Reset in the second multiply cycle aborts it
    op_in    = OPCODE_W'(12);
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    check("abort_busy_before", 32'(mul_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("mul_abort");
    idle(MUL_LAT + 2);
    send(10, 1, 2);
    idle(2);
`else
    // Multiply opcode is illegal and never stalls
    send(12, 0, 0);
    check("mul_illegal", 32'(illegal_op), 1);
    for (int i = 0; i < int'(MUL_LAT) + 1; i++) begin
      check("nomul_ready", 32'(op_ready), 1);
      check("nomul_busy",  32'(mul_busy), 0);
      tick();
    end
    send(2, 1, 0);
    idle(2);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
